// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared FSM states, owner tags and default parameters for sdram_arbiter
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VGA_RD   = 3'd1,
        CPU_RD   = 3'd2,
        CPU_WR   = 3'd3,
        CPU_WAIT = 3'd4
    } arb_state_t;

    localparam logic OWNER_VGA = 1'b0;
    localparam logic OWNER_CPU = 1'b1;

    localparam int DEF_ADDR_WIDTH      = 22;
    localparam int DEF_DATA_WIDTH      = 16;
    localparam int DEF_VGA_BURST       = 8;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_STARVE_LIMIT    = 4;

endpackage

// File: rtl/arb_owner_fifo.sv
// rtl/arb_owner_fifo.sv - 1-bit owner tag FIFO recording who issued each outstanding read
module arb_owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   push_data,
    input  logic                   pop,
    output logic                   pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] slots;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when an entry retires in the same cycle.
    assign do_push  = push && ((count < CW'(DEPTH)) || do_pop);
    assign pop_data = slots[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - VGA/CPU arbiter for one SDRAM controller port; SDRAM_ARB_STATS_EN adds grant/stall counters
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int VGA_BURST       = DEF_VGA_BURST,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vga_req,
    input  logic [ADDR_WIDTH-1:0]   vga_addr,
    output logic                    vga_ack,
    output logic [DATA_WIDTH-1:0]   vga_rdata,
    output logic                    vga_rvalid,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_be,
    output logic                    cpu_ack,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_rvalid,
    output logic                    rsp_err
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [31:0]             stat_vga_grants,
    output logic [31:0]             stat_cpu_grants,
    output logic [31:0]             stat_stall_cycles
`endif
);
    localparam int CNT_W = $clog2(VGA_BURST) + 1;
    localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    arb_state_t             state;
    arb_state_t             next_state;
    logic                   cpu_req_eff;
    logic                   grant_vga;
    logic                   grant_cpu;
    logic                   pop;
    logic                   issue_ok;
    logic                   rd_fire;
    logic                   wr_fire;
    logic                   fifo_empty;
    logic                   fifo_owner;
    logic [OW-1:0]          outstanding;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic [DATA_WIDTH/8-1:0] lat_be;
    logic [CNT_W-1:0]       issue_cnt;
    logic [SW-1:0]          starve_cnt;

    // The CPU still holds cpu_req during its ack cycle; do not grant that finished request twice.
    assign cpu_req_eff = cpu_req && !cpu_ack;
    assign grant_cpu   = (state == IDLE) && cpu_req_eff &&
                         (!vga_req || (starve_cnt == SW'(STARVE_LIMIT)));
    assign grant_vga   = (state == IDLE) && vga_req && !grant_cpu;
    assign pop         = mem_rvalid && !fifo_empty;
    assign issue_ok    = (outstanding < OW'(MAX_OUTSTANDING)) || pop;
    assign rd_fire     = mem_rd && !mem_waitrequest;
    assign wr_fire     = mem_wr && !mem_waitrequest;

    arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_fire),
        .push_data ((state == CPU_RD) ? OWNER_CPU : OWNER_VGA),
        .pop       (pop),
        .pop_data  (fifo_owner),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_cpu)      next_state = cpu_we ? CPU_WR : CPU_RD;
                else if (grant_vga) next_state = VGA_RD;
            end
            VGA_RD:   if (rd_fire && (issue_cnt == CNT_W'(VGA_BURST - 1))) next_state = IDLE;
            CPU_RD:   if (rd_fire) next_state = CPU_WAIT;
            CPU_WR:   if (wr_fire) next_state = IDLE;
            CPU_WAIT: if (pop && (fifo_owner == OWNER_CPU)) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = ((state == VGA_RD) || (state == CPU_RD)) && issue_ok;
        mem_wr    = (state == CPU_WR);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (state == VGA_RD) begin
            mem_addr = lat_addr + ADDR_WIDTH'(issue_cnt);
        end else if ((state == CPU_RD) || (state == CPU_WR)) begin
            mem_addr = lat_addr;
        end
        if (state == CPU_WR) begin
            mem_wdata = lat_wdata;
            mem_be    = lat_be;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_ack    <= 1'b0;
            vga_rvalid <= 1'b0;
            vga_rdata  <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            rsp_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            issue_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            vga_ack <= grant_vga;
            if (grant_vga || grant_cpu) lat_addr <= grant_vga ? vga_addr : cpu_addr;
            if (grant_cpu) begin
                lat_wdata <= cpu_wdata;
                lat_be    <= cpu_be;
            end
            if (grant_vga)                       issue_cnt <= '0;
            else if ((state == VGA_RD) && rd_fire) issue_cnt <= issue_cnt + 1'b1;
            if (grant_cpu || !cpu_req) starve_cnt <= '0;
            else if (grant_vga)        starve_cnt <= starve_cnt + 1'b1;
            vga_rvalid <= pop && (fifo_owner == OWNER_VGA);
            if (pop && (fifo_owner == OWNER_VGA)) vga_rdata <= mem_rdata;
            cpu_ack <= wr_fire || (pop && (fifo_owner == OWNER_CPU));
            if (pop && (fifo_owner == OWNER_CPU)) cpu_rdata <= mem_rdata;
            if (mem_rvalid && fifo_empty) rsp_err <= 1'b1;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_vga_grants   <= '0;
            stat_cpu_grants   <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (grant_vga) stat_vga_grants <= stat_vga_grants + 1'b1;
            if (grant_cpu) stat_cpu_grants <= stat_cpu_grants + 1'b1;
            if ((mem_rd || mem_wr) && mem_waitrequest) stat_stall_cycles <= stat_stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters: the VGA framebuffer line prefetcher and the CPU load/store unit.
- VGA issues fixed-length sequential read bursts. The CPU issues single-word reads and writes.
- The block sits in top between the requesters and the SDRAM controller's Avalon-style master interface.
- It tracks the owner of every outstanding read, so returned data is routed back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 22, word address width (12 row + 8 col + 2 bank).
- DATA_WIDTH, 16, SDRAM data width.
- VGA_BURST, 8, reads issued per VGA grant (power of 2, 1..64).
- MAX_OUTSTANDING, 4, maximum reads in flight (power of 2).
- STARVE_LIMIT, 4, number of consecutive VGA grants allowed while a CPU request waits.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- vga_req  input  1  burst request; held high until vga_ack.
- vga_addr  input  ADDR_WIDTH  burst start address.
- vga_ack  output  1  one-cycle pulse when the burst is granted.
- vga_rdata  output  DATA_WIDTH  read data to VGA.
- vga_rvalid  output  1  vga_rdata valid.
- cpu_req  input  1  access request; held high with stable fields until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_WIDTH  word address.
- cpu_wdata  input  DATA_WIDTH  write data.
- cpu_be  input  DATA_WIDTH/8  byte enables.
- cpu_ack  output  1  one-cycle pulse: write accepted, or read data valid.
- cpu_rdata  output  DATA_WIDTH  read data, valid with cpu_ack on reads.
- mem_addr  output  ADDR_WIDTH  command address.
- mem_rd  output  1  read command.
- mem_wr  output  1  write command.
- mem_wdata  output  DATA_WIDTH  write data.
- mem_be  output  DATA_WIDTH/8  byte enables.
- mem_waitrequest  input  1  controller stall; the command holds while high.
- mem_rdata  input  DATA_WIDTH  returned read data.
- mem_rvalid  input  1  mem_rdata valid; responses return in order.
- rsp_err  output  1  sticky flag: mem_rvalid arrived with no outstanding read.

Behaviour:
- Reset (async assert, sync deassert):
  - Every output is 0.
  - FSM goes to IDLE; owner FIFO is emptied; starvation counter is cleared.
  - Responses arriving after reset for pre-reset commands are dropped and set rsp_err.
- FSM states: IDLE, VGA_RD, CPU_RD, CPU_WR, CPU_WAIT.
- IDLE arbitration: fixed priority, VGA first, non-preemptive.
  - CPU wins if cpu_req is high and either vga_req is low or starve_cnt == STARVE_LIMIT.
  - On a grant, the winner's fields are latched and its ack rises the next cycle.
  - vga_ack pulses on entry to VGA_RD.
- VGA_RD:
  - Issues VGA_BURST reads at vga_addr+i, i = 0..VGA_BURST-1. The address wraps modulo 2^ADDR_WIDTH.
  - A read is counted as issued when mem_rd=1 and mem_waitrequest=0.
  - mem_rd deasserts while outstanding == MAX_OUTSTANDING. If a response retires in the same cycle, issue continues.
  - After the last read is issued, go to IDLE. The remaining responses drain through the FIFO.
  - starve_cnt increments per VGA grant only while cpu_req is high. It clears on any CPU grant or when cpu_req is low.
- CPU_WR:
  - mem_wr is asserted with the latched fields until mem_waitrequest=0.
  - cpu_ack pulses on the next cycle; then go to IDLE.
- CPU_RD: issues one read (subject to the outstanding limit), then goes to CPU_WAIT.
- CPU_WAIT: waits for the CPU-owned response. On it, drive cpu_rdata = mem_rdata and pulse cpu_ack (registered, 1-cycle latency); then go to IDLE.
- Owner FIFO:
  - Depth MAX_OUTSTANDING, 1 bit per entry (0 = VGA, 1 = CPU).
  - Pushed on read issue, popped on mem_rvalid.
  - Push and pop in the same cycle keep the count unchanged.
- Routing: the popped owner selects the vga_rvalid/vga_rdata or cpu_ack/cpu_rdata register. Both are registered, 1 cycle after mem_rvalid.
- mem_rvalid with the FIFO empty: data is dropped and rsp_err is set; rsp_err clears only on reset.
- mem_rd and mem_wr are never high together. Commands are held stable while mem_waitrequest is high.

Optional Feature:
- Macro: SDRAM_ARB_STATS_EN.
- Defined: adds outputs stat_vga_grants[31:0], stat_cpu_grants[31:0] and stat_stall_cycles[31:0].
  - stat_stall_cycles counts cycles with a command asserted and mem_waitrequest high.
  - Counters wrap and reset to 0.
- Undefined: the ports and counters are absent; the core function is unchanged.

Decomposition:
- Shared package sdram_arb_pkg:
  - FSM state enum.
  - OWNER_VGA / OWNER_CPU constants.
  - Default parameter constants.
- Sub-module: arb_owner_fifo, a parameterised 1-bit synchronous FIFO with count output, reset async active-low.

Test Plan:
- VGA only, vga_addr=0x000100, waitrequest low → 8 reads at 0x100..0x107; vga_rvalid ×8 with data in order; cpu_ack never pulses.
- CPU write 0x3FFFFF, data 0xBEEF, be=2'b11, waitrequest high 3 cycles → mem_wr held 4 cycles with stable fields; cpu_ack 1 cycle after acceptance.
- vga_req and cpu_req continuously high, STARVE_LIMIT=4 → grant order VGA,VGA,VGA,VGA,CPU, repeating; CPU read data routed only to cpu_rdata.
- VGA burst at vga_addr=0x3FFFFC → addresses 0x3FFFFC..0x3FFFFF, 0x000000..0x000003; with response latency 10, outstanding reads never exceed 4.
- Reset asserted mid-burst after 3 issues, 2 late mem_rvalid pulses after release → outputs 0 during reset; rsp_err=1; no vga_rvalid.
- With SDRAM_ARB_STATS_EN: 2 VGA grants, 1 CPU grant, 5 stalled cycles → counters read 2, 1, 5.
